// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand-loader FSM encoding, default widths and the
// opcode map used by the ALU, the operand loader and the output register.
package alu_pkg;

   localparam int WIDTH_DEF    = 32;
   localparam int OP_WIDTH_DEF = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'b00;
   localparam state_t ST_COLLECT = 2'b01;
   localparam state_t ST_ISSUE   = 2'b10;

   localparam logic [OP_WIDTH_DEF-1:0] OP_ADD = 4'h0;
   localparam logic [OP_WIDTH_DEF-1:0] OP_SUB = 4'h1;
   localparam logic [OP_WIDTH_DEF-1:0] OP_AND = 4'h2;
   localparam logic [OP_WIDTH_DEF-1:0] OP_OR  = 4'h3;
   localparam logic [OP_WIDTH_DEF-1:0] OP_XOR = 4'h4;
   localparam logic [OP_WIDTH_DEF-1:0] OP_SHL = 4'h5;
   localparam logic [OP_WIDTH_DEF-1:0] OP_SHR = 4'h6;
   localparam logic [OP_WIDTH_DEF-1:0] OP_CMP = 4'h7;

   // Where the collection side should sit given the post-edge field flags.
   function automatic state_t fill_state(input logic a, input logic b, input logic op);
      if (a && b && op)
         fill_state = ST_ISSUE;
      else if (a || b || op)
         fill_state = ST_COLLECT;
      else
         fill_state = ST_IDLE;
   endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Bus/control/ALU-side signal bundle of the operand loader. The slave modport
// is the loader itself; the master modport is whoever drives it.
interface alu_operand_loader_if #(
   parameter int WIDTH    = 32,
   parameter int OP_WIDTH = 4
);
   logic [WIDTH-1:0]    BUS_IN;
   logic                load_a;
   logic                load_b;
   logic                load_op;
   logic [OP_WIDTH-1:0] op_in;
   logic                flush;
   logic                alu_ready;
   logic                clear_err;
   logic [WIDTH-1:0]    OPERAND_A;
   logic [WIDTH-1:0]    OPERAND_B;
   logic [OP_WIDTH-1:0] ALU_OP;
   logic                alu_valid;
   logic                load_rdy;
   logic                have_a;
   logic                have_b;
   logic                have_op;
   logic                overrun;

   modport master (
      output BUS_IN, load_a, load_b, load_op, op_in, flush, alu_ready, clear_err,
      input  OPERAND_A, OPERAND_B, ALU_OP, alu_valid, load_rdy,
             have_a, have_b, have_op, overrun
   );

   modport slave (
      input  BUS_IN, load_a, load_b, load_op, op_in, flush, alu_ready, clear_err,
      output OPERAND_A, OPERAND_B, ALU_OP, alu_valid, load_rdy,
             have_a, have_b, have_op, overrun
   );
endinterface

// File: rtl/alu_operand_field.sv
// One operand/opcode slot: load-enabled value register plus a "captured" flag.
// Clearing drops only the flag; the value is kept for the ALU after handoff.
module alu_operand_field #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         have
);

   logic [W-1:0] val_d, val_q;
   logic         have_d, have_q;

   always_comb begin
      val_d  = val_q;
      have_d = have_q;
      if (load) begin
         val_d  = d;
         have_d = 1'b1;
      end
      if (clear)
         have_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q  <= '0;
         have_q <= 1'b0;
      end else begin
         val_q  <= val_d;
         have_q <= have_d;
      end
   end

   assign q    = val_q;
   assign have = have_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Collects operand A, operand B and opcode from the shared bus, then offers
// the complete set to the ALU over a valid/ready handshake.
module alu_operand_loader
   import alu_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int OP_WIDTH = OP_WIDTH_DEF
) (
   input  logic clk,
   input  logic rst_n,
   alu_operand_loader_if.slave bus
);

   state_t state_d, state_q;
   logic   alu_valid_d, alu_valid_q;
   logic   overrun_d, overrun_q;

   logic   in_issue, accept, handoff, clr;
   logic   ld_a, ld_b, ld_op, any_load;
   logic   have_a, have_b, have_op;
   logic   nxt_a, nxt_b, nxt_op;

   logic [WIDTH-1:0]    opa, opb;
   logic [OP_WIDTH-1:0] opc;

   // Loads are accepted only outside ISSUE, and flush overrides everything.
   always_comb begin
      in_issue = (state_q == ST_ISSUE);
      accept   = !in_issue && !bus.flush;
      any_load = bus.load_a || bus.load_b || bus.load_op;
      ld_a     = bus.load_a  && accept;
      ld_b     = bus.load_b  && accept;
      ld_op    = bus.load_op && accept;
      handoff  = in_issue && bus.alu_ready && !bus.flush;
      clr      = bus.flush || handoff;
      nxt_a    = !clr && (have_a  || ld_a);
      nxt_b    = !clr && (have_b  || ld_b);
      nxt_op   = !clr && (have_op || ld_op);
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush)
         state_d = ST_IDLE;
      else if (in_issue)
         state_d = handoff ? ST_IDLE : ST_ISSUE;
      else
         state_d = fill_state(nxt_a, nxt_b, nxt_op);
      alu_valid_d = (state_d == ST_ISSUE);
   end

   // A set request in the same cycle as clear_err must win; flush leaves it alone.
   always_comb begin
      overrun_d = overrun_q;
      if (bus.clear_err)
         overrun_d = 1'b0;
      if (in_issue && any_load && !bus.flush)
         overrun_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         alu_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         alu_valid_q <= alu_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   alu_operand_field #(.W(WIDTH)) u_field_a (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (ld_a),
      .clear (clr),
      .d     (bus.BUS_IN),
      .q     (opa),
      .have  (have_a)
   );

   alu_operand_field #(.W(WIDTH)) u_field_b (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (ld_b),
      .clear (clr),
      .d     (bus.BUS_IN),
      .q     (opb),
      .have  (have_b)
   );

   alu_operand_field #(.W(OP_WIDTH)) u_field_op (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (ld_op),
      .clear (clr),
      .d     (bus.op_in),
      .q     (opc),
      .have  (have_op)
   );

   assign bus.OPERAND_A = opa;
   assign bus.OPERAND_B = opb;
   assign bus.ALU_OP    = opc;
   assign bus.alu_valid = alu_valid_q;
   assign bus.load_rdy  = (state_q != ST_ISSUE);
   assign bus.have_a    = have_a;
   assign bus.have_b    = have_b;
   assign bus.have_op   = have_op;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader: each task drives one scenario and
// checks the loader outputs against hand-computed values.
module tb_alu_operand_loader;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_operand_loader_if #(.WIDTH(32), .OP_WIDTH(4)) bus ();

   alu_operand_loader #(.WIDTH(32), .OP_WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic idle_inputs();
      bus.load_a    = 1'b0;
      bus.load_b    = 1'b0;
      bus.load_op   = 1'b0;
      bus.flush     = 1'b0;
      bus.alu_ready = 1'b0;
      bus.clear_err = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic test_reset();
      bus.BUS_IN = 32'h0;
      bus.op_in  = 4'h0;
      idle_inputs();
      rst_n = 1'b0;
      #2;
      checks++; if (bus.OPERAND_A !== 32'h0) begin errors++; $display("FAIL reset_opa got %h exp %h", bus.OPERAND_A, 32'h0); end
      checks++; if (bus.OPERAND_B !== 32'h0) begin errors++; $display("FAIL reset_opb got %h exp %h", bus.OPERAND_B, 32'h0); end
      checks++; if (bus.ALU_OP !== 4'h0) begin errors++; $display("FAIL reset_op got %h exp %h", bus.ALU_OP, 4'h0); end
      checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.alu_valid); end
      checks++; if (bus.load_rdy !== 1'b1) begin errors++; $display("FAIL reset_load_rdy got %b exp 1", bus.load_rdy); end
      checks++; if ({bus.have_a, bus.have_b, bus.have_op, bus.overrun} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b exp 0000", {bus.have_a, bus.have_b, bus.have_op, bus.overrun}); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (bus.load_rdy !== 1'b1 || bus.alu_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle got rdy=%b vld=%b exp rdy=1 vld=0", bus.load_rdy, bus.alu_valid); end
   endtask

   task automatic test_ordered_load();
      bus.BUS_IN = 32'h0000_0005; bus.load_a = 1'b1;
      tick();
      checks++; if (bus.have_a !== 1'b1 || bus.alu_valid !== 1'b0 || bus.load_rdy !== 1'b1) begin
         errors++; $display("FAIL ord_collect got have_a=%b vld=%b rdy=%b exp 1 0 1", bus.have_a, bus.alu_valid, bus.load_rdy); end
      bus.BUS_IN = 32'h0000_0003; bus.load_b = 1'b1; bus.load_op = 1'b1; bus.op_in = 4'h1;
      tick();
      checks++; if (bus.alu_valid !== 1'b1) begin errors++; $display("FAIL ord_valid got %b exp 1", bus.alu_valid); end
      checks++; if (bus.OPERAND_A !== 32'h5 || bus.OPERAND_B !== 32'h3 || bus.ALU_OP !== 4'h1) begin
         errors++; $display("FAIL ord_operands got %h %h %h exp 5 3 1", bus.OPERAND_A, bus.OPERAND_B, bus.ALU_OP); end
      checks++; if (bus.load_rdy !== 1'b0) begin errors++; $display("FAIL ord_load_rdy got %b exp 0", bus.load_rdy); end
      bus.alu_ready = 1'b1;
      tick();
      checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL ord_handoff_valid got %b exp 0", bus.alu_valid); end
      checks++; if (bus.OPERAND_A !== 32'h5 || bus.OPERAND_B !== 32'h3) begin
         errors++; $display("FAIL ord_retain got %h %h exp 5 3", bus.OPERAND_A, bus.OPERAND_B); end
      checks++; if ({bus.have_a, bus.have_b, bus.have_op} !== 3'b000 || bus.load_rdy !== 1'b1) begin
         errors++; $display("FAIL ord_idle got have=%b rdy=%b exp 000 1", {bus.have_a, bus.have_b, bus.have_op}, bus.load_rdy); end
   endtask

   task automatic test_simultaneous();
      bus.BUS_IN = 32'hDEAD_BEEF; bus.op_in = 4'h2;
      bus.load_a = 1'b1; bus.load_b = 1'b1; bus.load_op = 1'b1;
      tick();
      checks++; if (bus.OPERAND_A !== 32'hDEAD_BEEF || bus.OPERAND_B !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL sim_operands got %h %h exp deadbeef deadbeef", bus.OPERAND_A, bus.OPERAND_B); end
      checks++; if (bus.alu_valid !== 1'b1 || bus.ALU_OP !== 4'h2) begin
         errors++; $display("FAIL sim_valid got vld=%b op=%h exp 1 2", bus.alu_valid, bus.ALU_OP); end
      bus.alu_ready = 1'b1;
      tick();
      checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL sim_handoff got %b exp 0", bus.alu_valid); end
   endtask

   task automatic test_overwrite();
      bus.BUS_IN = 32'h11; bus.load_a = 1'b1;
      tick();
      bus.BUS_IN = 32'h22; bus.load_a = 1'b1;
      tick();
      checks++; if (bus.OPERAND_A !== 32'h22 || bus.have_a !== 1'b1 || bus.alu_valid !== 1'b0) begin
         errors++; $display("FAIL ovw_reload got %h have=%b vld=%b exp 22 1 0", bus.OPERAND_A, bus.have_a, bus.alu_valid); end
      bus.BUS_IN = 32'h33; bus.load_b = 1'b1; bus.load_op = 1'b1; bus.op_in = 4'h3;
      tick();
      checks++; if (bus.alu_valid !== 1'b1 || bus.OPERAND_A !== 32'h22 || bus.OPERAND_B !== 32'h33) begin
         errors++; $display("FAIL ovw_issue got vld=%b %h %h exp 1 22 33", bus.alu_valid, bus.OPERAND_A, bus.OPERAND_B); end
   endtask

   task automatic test_overrun();
      // entered in ISSUE with A=22, B=33, op=3
      bus.BUS_IN = 32'h99; bus.load_a = 1'b1;
      tick();
      checks++; if (bus.OPERAND_A !== 32'h22) begin errors++; $display("FAIL ovr_hold_a got %h exp 22", bus.OPERAND_A); end
      checks++; if (bus.overrun !== 1'b1 || bus.alu_valid !== 1'b1) begin
         errors++; $display("FAIL ovr_set got ovr=%b vld=%b exp 1 1", bus.overrun, bus.alu_valid); end
      bus.BUS_IN = 32'h44; bus.load_b = 1'b1; bus.clear_err = 1'b1;
      tick();
      checks++; if (bus.overrun !== 1'b1 || bus.OPERAND_B !== 32'h33) begin
         errors++; $display("FAIL ovr_set_wins got ovr=%b b=%h exp 1 33", bus.overrun, bus.OPERAND_B); end
      bus.clear_err = 1'b1;
      tick();
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", bus.overrun); end
      bus.alu_ready = 1'b1; bus.BUS_IN = 32'h55; bus.load_a = 1'b1;
      tick();
      checks++; if (bus.alu_valid !== 1'b0 || bus.have_a !== 1'b0 || bus.OPERAND_A !== 32'h22) begin
         errors++; $display("FAIL ovr_exit_load got vld=%b have_a=%b a=%h exp 0 0 22", bus.alu_valid, bus.have_a, bus.OPERAND_A); end
      checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_exit_flag got %b exp 1", bus.overrun); end
      bus.clear_err = 1'b1;
      tick();
      checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear2 got %b exp 0", bus.overrun); end
   endtask

   task automatic test_ready_idle_and_flush_collect();
      bus.alu_ready = 1'b1; bus.BUS_IN = 32'h66; bus.load_a = 1'b1;
      tick();
      checks++; if (bus.have_a !== 1'b1 || bus.OPERAND_A !== 32'h66 || bus.alu_valid !== 1'b0 || bus.load_rdy !== 1'b1) begin
         errors++; $display("FAIL rdy_idle got have_a=%b a=%h vld=%b rdy=%b exp 1 66 0 1",
                            bus.have_a, bus.OPERAND_A, bus.alu_valid, bus.load_rdy); end
      bus.flush = 1'b1; bus.BUS_IN = 32'h70; bus.load_b = 1'b1;
      tick();
      checks++; if (bus.have_a !== 1'b0 || bus.have_b !== 1'b0 || bus.OPERAND_B !== 32'h33 || bus.OPERAND_A !== 32'h66) begin
         errors++; $display("FAIL flush_collect got have=%b%b a=%h b=%h exp 00 66 33",
                            bus.have_a, bus.have_b, bus.OPERAND_A, bus.OPERAND_B); end
   endtask

   task automatic test_flush_issue();
      bus.BUS_IN = 32'h77; bus.op_in = 4'h5;
      bus.load_a = 1'b1; bus.load_b = 1'b1; bus.load_op = 1'b1;
      tick();
      checks++; if (bus.alu_valid !== 1'b1) begin errors++; $display("FAIL fl_pre_valid got %b exp 1", bus.alu_valid); end
      bus.flush = 1'b1; bus.alu_ready = 1'b1; bus.BUS_IN = 32'hAA; bus.load_a = 1'b1;
      tick();
      checks++; if (bus.alu_valid !== 1'b0 || {bus.have_a, bus.have_b, bus.have_op} !== 3'b000) begin
         errors++; $display("FAIL fl_drop got vld=%b have=%b exp 0 000", bus.alu_valid, {bus.have_a, bus.have_b, bus.have_op}); end
      checks++; if (bus.OPERAND_A !== 32'h77 || bus.overrun !== 1'b0 || bus.load_rdy !== 1'b1) begin
         errors++; $display("FAIL fl_keep got a=%h ovr=%b rdy=%b exp 77 0 1", bus.OPERAND_A, bus.overrun, bus.load_rdy); end
      tick();
      checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL fl_no_reissue got %b exp 0", bus.alu_valid); end
      bus.BUS_IN = 32'h12; bus.op_in = 4'h6;
      bus.load_a = 1'b1; bus.load_b = 1'b1; bus.load_op = 1'b1;
      tick();
      checks++; if (bus.alu_valid !== 1'b1 || bus.OPERAND_A !== 32'h12 || bus.ALU_OP !== 4'h6) begin
         errors++; $display("FAIL fl_reissue got vld=%b a=%h op=%h exp 1 12 6", bus.alu_valid, bus.OPERAND_A, bus.ALU_OP); end
   endtask

   task automatic test_reset_mid_issue();
      // entered in ISSUE with A=B=12, op=6
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.alu_valid !== 1'b0 || bus.load_rdy !== 1'b1) begin
         errors++; $display("FAIL rst_issue_valid got vld=%b rdy=%b exp 0 1", bus.alu_valid, bus.load_rdy); end
      checks++; if (bus.OPERAND_A !== 32'h0 || bus.ALU_OP !== 4'h0 || bus.have_op !== 1'b0) begin
         errors++; $display("FAIL rst_issue_regs got a=%h op=%h have_op=%b exp 0 0 0", bus.OPERAND_A, bus.ALU_OP, bus.have_op); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (bus.alu_valid !== 1'b0) begin errors++; $display("FAIL rst_issue_after got %b exp 0", bus.alu_valid); end
   endtask

   initial begin
      test_reset();
      test_ordered_load();
      test_simultaneous();
      test_overwrite();
      test_overrun();
      test_ready_idle_and_flush_collect();
      test_flush_issue();
      test_reset_mid_issue();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Bus-side counterpart of the ALU output register. It reads operands from the shared 32-bit data bus and presents them to the ALU; the output register is what writes results back onto that bus.
- Captures operand A, operand B and an opcode, each under its own load strobe. It then raises a valid/ready issue handshake towards the ALU and holds the operands stable until the ALU accepts them.
- Sits between the bus and the ALU inputs, driven by the control unit's load strobes.

Parameters:
- WIDTH, 32, data bus and operand width.
- OP_WIDTH, 4, ALU opcode width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- BUS_IN  in  WIDTH  shared data bus (read only).
- load_a  in  1  capture BUS_IN into operand A.
- load_b  in  1  capture BUS_IN into operand B.
- load_op  in  1  capture op_in into the opcode register.
- op_in  in  OP_WIDTH  opcode from the control unit.
- flush  in  1  synchronous abort: drop collected operands and any pending issue.
- alu_ready  in  1  ALU accepts the current operand set.
- clear_err  in  1  synchronous clear of the overrun flag.
- OPERAND_A  out  WIDTH  operand A to the ALU.
- OPERAND_B  out  WIDTH  operand B to the ALU.
- ALU_OP  out  OP_WIDTH  opcode to the ALU.
- alu_valid  out  1  operand set complete and offered to the ALU.
- load_rdy  out  1  block accepts loads (high in IDLE/COLLECT).
- have_a, have_b, have_op  out  1 each  per-field captured flags.
- overrun  out  1  sticky: a load arrived while in ISSUE.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - OPERAND_A, OPERAND_B, ALU_OP = 0.
  - All have_* = 0, alu_valid = 0, overrun = 0, load_rdy = 1.
- FSM states:
  - IDLE: no field captured.
  - COLLECT: at least one field captured, not all three.
  - ISSUE: all three captured, alu_valid=1.
- Loads in IDLE/COLLECT:
  - Each asserted strobe captures its source at the clock edge and sets its have_* flag.
  - Any subset may assert in the same cycle. load_a and load_b together load the same BUS_IN value into both operands.
  - Re-loading an already captured field overwrites it; the flag stays set.
- Transitions:
  - IDLE→COLLECT on any load that leaves the set incomplete.
  - IDLE/COLLECT→ISSUE on the edge where all three flags become set. alu_valid rises the cycle after the final strobe (latency 1). It is registered, not combinational from the strobes.
- ISSUE:
  - OPERAND_A, OPERAND_B, ALU_OP are held stable; load_rdy=0.
  - Any load_* strobe is ignored (no register change) and sets overrun.
  - On an edge with alu_ready=1: all flags clear, state→IDLE, alu_valid=0 next cycle.
  - Operand/opcode registers retain their values after handoff; they are not zeroed.
  - alu_ready while not in ISSUE has no effect.
- Simultaneous events:
  - In the cycle ISSUE exits, a coincident load is still ignored and flagged. Loads are accepted from the following cycle.
  - flush has priority over loads and alu_ready in every state. It clears flags and alu_valid and sends the FSM to IDLE. Operand registers are unchanged; overrun is unchanged.
  - clear_err and an overrun-setting load in the same cycle: set wins (flag stays 1).
- Reset mid-ISSUE drops alu_valid immediately (async) with no handshake completion.

Decomposition:
- Shared package alu_pkg:
  - FSM state typedef (IDLE, COLLECT, ISSUE).
  - WIDTH/OP_WIDTH defaults.
  - Opcode constants shared with the ALU and the output register.
- One natural sub-module: alu_operand_field, a WIDTH-parameterised load-enable register with a have flag and clear, instantiated for A, B and op. FSM and handshake logic stay in the top.

Test Plan:
- Reset: rst_n=0 mid-cycle → all outputs 0 immediately except load_rdy=1; release → IDLE.
- Ordered load:
  - BUS_IN=0x0000_0005 with load_a.
  - Next cycle BUS_IN=0x0000_0003 with load_b and load_op, op_in=4'h1.
  - Expect alu_valid=1 one cycle later, OPERAND_A=5, OPERAND_B=3, ALU_OP=1.
  - alu_ready=1 → alu_valid=0 next cycle, operands remain 5/3.
- Simultaneous A/B: load_a=load_b=load_op=1, BUS_IN=0xDEAD_BEEF → both operands 0xDEADBEEF, alu_valid next cycle.
- Overwrite: load_a with 0x11, then load_a with 0x22, then load_b/load_op → issued OPERAND_A=0x22.
- Overrun:
  - In ISSUE with alu_ready=0, load_a with BUS_IN=0x99 → OPERAND_A unchanged, overrun=1, alu_valid stays 1.
  - clear_err → overrun=0.
- Flush in ISSUE with alu_ready=1 the same cycle → IDLE, alu_valid=0, have_*=0, no second issue. A new full load re-issues normally.
